// File: rtl/arbq_pkg.sv
// Package: arbq_pkg
//
// Shared types and constants for the arbiter request queue.
//   client_t   - 1-bit client index
//   CLIENT0/1  - client index constants
//   STALE_MAX  - saturation value of the optional stale-grant counter
//   ptr_w()    - FIFO pointer width (address bits plus one wrap bit)
package arbq_pkg;

  typedef logic client_t;

  localparam client_t    CLIENT0   = 1'b0;
  localparam client_t    CLIENT1   = 1'b1;
  localparam logic [7:0] STALE_MAX = 8'hFF;

  // The extra MSB distinguishes full from empty when the low bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arbq_fifo.sv
// Module: arbq_fifo
//
// Single-client FIFO with a combinational head read.
// A push while full is ignored. A pop while empty is ignored.
// A push and a pop in the same cycle both take effect.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset (clears the pointers)
//   push_i       write strobe
//   push_data_i  payload to write
//   pop_i        remove the head entry
//   full_o       no free entries
//   empty_o      no stored entries
//   head_o       payload at the head of the queue
module arbq_fifo
  import arbq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/arb_request_queue.sv
// Module: arb_request_queue
//
// This module feeds a 2-client arbiter. Each client has its own FIFO.
// The request output is driven from FIFO occupancy. The grant input is consumed
// so that at most one granted head is popped per cycle. The popped head goes to
// a registered output. When both clients are eligible, the module alternates
// between them.
//
// Optional feature: define ARBQ_STALE_CNT_EN to add the stale_cnt output.
// stale_cnt is a saturating count of grant bits that arrive for an empty FIFO.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-low reset
//   in_valid    per-client push strobe
//   in_data0/1  client payloads
//   in_ready    per-client push accepted (FIFO not full)
//   request     to arbiter, FIFO not empty
//   grant       from arbiter
//   out_valid   one-cycle pulse per popped entry
//   out_client  client index of popped entry
//   out_data    popped payload
//   stale_cnt   (ARBQ_STALE_CNT_EN only) stale-grant counter
module arb_request_queue
  import arbq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic [1:0]        in_ready,
  output logic [1:0]        request,
  input  logic [1:0]        grant,
  output logic              out_valid,
  output logic              out_client,
`ifdef ARBQ_STALE_CNT_EN
  output logic [7:0]        stale_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] in_data_arr [2];
  logic [DATA_W-1:0] head_arr    [2];
  logic [1:0]        full, empty, pop, elig;
  logic              pop_en;
  client_t           sel;

  client_t           last_served_q;
  logic              out_valid_q;
  client_t           out_client_q;
  logic [DATA_W-1:0] out_data_q;

  assign in_data_arr[0] = in_data0;
  assign in_data_arr[1] = in_data1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      arbq_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (in_valid[gi]),
        .push_data_i (in_data_arr[gi]),
        .pop_i       (pop[gi]),
        .full_o      (full[gi]),
        .empty_o     (empty[gi]),
        .head_o      (head_arr[gi])
      );
    end
  endgenerate

  assign in_ready = ~full;
  assign request  = ~empty;

  // A grant that arrives for an empty FIFO is left over from the previous
  // request. Masking grant with ~empty keeps such a grant from producing a pop.
  always_comb begin
    elig   = grant & ~empty;
    pop_en = |elig;
    unique case (elig)
      2'b01:   sel = CLIENT0;
      2'b10:   sel = CLIENT1;
      2'b11:   sel = ~last_served_q;
      default: sel = CLIENT0;
    endcase
    pop[0] = pop_en && (sel == CLIENT0);
    pop[1] = pop_en && (sel == CLIENT1);
  end

  // last_served resets to 1, so client 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_served_q <= CLIENT1;
      out_valid_q   <= 1'b0;
      out_client_q  <= CLIENT0;
      out_data_q    <= '0;
    end else begin
      out_valid_q <= pop_en;
      if (pop_en) begin
        last_served_q <= sel;
        out_client_q  <= sel;
        out_data_q    <= head_arr[sel];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_client = out_client_q;
  assign out_data   = out_data_q;

`ifdef ARBQ_STALE_CNT_EN
  logic [1:0] stale_bits;
  logic [8:0] stale_sum;
  logic [7:0] stale_cnt_q, stale_cnt_d;

  always_comb begin
    stale_bits  = grant & empty;
    stale_sum   = {1'b0, stale_cnt_q} + {8'd0, stale_bits[0]} + {8'd0, stale_bits[1]};
    stale_cnt_d = stale_sum[8] ? STALE_MAX : stale_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stale_cnt_q <= '0;
    else        stale_cnt_q <= stale_cnt_d;
  end

  assign stale_cnt = stale_cnt_q;
`endif

endmodule

// File: tb/tb_arb_request_queue.sv
module tb_arb_request_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] in_valid = 2'b00;
  logic [7:0] in_data0 = 8'h00;
  logic [7:0] in_data1 = 8'h00;
  logic [1:0] in_ready;
  logic [1:0] request;
  logic [1:0] grant = 2'b00;
  logic       out_valid;
  logic       out_client;
  logic [7:0] out_data;
`ifdef ARBQ_STALE_CNT_EN
  logic [7:0] stale_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  arb_request_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .in_ready   (in_ready),
    .request    (request),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_client (out_client),
`ifdef ARBQ_STALE_CNT_EN
    .stale_cnt  (stale_cnt),
`endif
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 2'b00;
    grant    = 2'b00;
    reset    = 1'b0;
    step();
    step();
    reset    = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (request !== 2'b00) $display("FAIL reset_req: got %b expected 00", request); else pass_cnt++;
    total_cnt++; if (in_ready !== 2'b11) $display("FAIL reset_ready: got %b expected 11", in_ready); else pass_cnt++;
    // Mid-traffic: fill both FIFOs and pop one entry, then reset asynchronously.
    in_valid = 2'b11; in_data0 = 8'h11; in_data1 = 8'h22;
    step();
    in_valid = 2'b00; grant = 2'b11;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h11) $display("FAIL reset_pre_pop: got v=%b d=%h expected v=1 d=11", out_valid, out_data); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (request !== 2'b00) $display("FAIL reset_async_req: got %b expected 00", request); else pass_cnt++;
    total_cnt++; if (in_ready !== 2'b11) $display("FAIL reset_async_ready: got %b expected 11", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_client !== 1'b0) $display("FAIL reset_async_out: got v=%b c=%b d=%h expected 0 0 00", out_valid, out_client, out_data); else pass_cnt++;
    grant = 2'b00;
    step();
    reset = 1'b1;
    step();
    total_cnt++; if (request !== 2'b00 || out_valid !== 1'b0) $display("FAIL reset_release: got req=%b v=%b expected 00 0", request, out_valid); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single_client();
    logic [7:0] exp_d [2];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2;
    do_reset();
    in_valid = 2'b01; in_data0 = 8'hA1; step();
    in_data0 = 8'hA2; step();
    in_valid = 2'b00;
    total_cnt++; if (request !== 2'b01) $display("FAIL single_req: got %b expected 01", request); else pass_cnt++;
    grant = 2'b01;
    for (int i = 0; i < 2; i++) begin
      step();
      $display("pop single: v=%b c=%b d=%h", out_valid, out_client, out_data);
      total_cnt++; if (out_valid !== 1'b1 || out_client !== 1'b0 || out_data !== exp_d[i]) $display("FAIL single_pop%0d: got v=%b c=%b d=%h expected 1 0 %h", i, out_valid, out_client, out_data, exp_d[i]); else pass_cnt++;
    end
    total_cnt++; if (request !== 2'b00) $display("FAIL single_req_fall: got %b expected 00", request); else pass_cnt++;
    step();  // stale grant on now-empty FIFO
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_stale: got v=%b expected 0", out_valid); else pass_cnt++;
    grant = 2'b00;
  endtask

  task automatic test_tie();
    logic [7:0] exp_d [6];
    logic       exp_c [6];
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11;
    exp_d[3] = 8'h21; exp_d[4] = 8'h12; exp_d[5] = 8'h22;
    exp_c[0] = 1'b0; exp_c[1] = 1'b1; exp_c[2] = 1'b0;
    exp_c[3] = 1'b1; exp_c[4] = 1'b0; exp_c[5] = 1'b1;
    do_reset();
    in_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in_data0 = 8'h10 + 8'(i); in_data1 = 8'h20 + 8'(i);
      step();
    end
    in_valid = 2'b00;
    grant = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      $display("pop tie: v=%b c=%b d=%h", out_valid, out_client, out_data);
      total_cnt++; if (out_valid !== 1'b1 || out_client !== exp_c[i] || out_data !== exp_d[i]) $display("FAIL tie_pop%0d: got v=%b c=%b d=%h expected 1 %b %h", i, out_valid, out_client, out_data, exp_c[i], exp_d[i]); else pass_cnt++;
    end
    step();
    total_cnt++; if (out_valid !== 1'b0 || request !== 2'b00) $display("FAIL tie_end: got v=%b req=%b expected 0 00", out_valid, request); else pass_cnt++;
    grant = 2'b00;
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      in_data1 = 8'h40 + 8'(i);
      step();
    end
    total_cnt++; if (in_ready !== 2'b01) $display("FAIL full_ready: got %b expected 01", in_ready); else pass_cnt++;
    in_data1 = 8'h55;  // held while full: must be dropped
    step();
    in_valid = 2'b00;
    total_cnt++; if (in_ready !== 2'b01) $display("FAIL full_hold: got %b expected 01", in_ready); else pass_cnt++;
    grant = 2'b10;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_client !== 1'b1 || out_data !== 8'h40) $display("FAIL full_pop0: got v=%b c=%b d=%h expected 1 1 40", out_valid, out_client, out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 2'b11) $display("FAIL full_ready_back: got %b expected 11", in_ready); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      step();
      $display("pop full: v=%b c=%b d=%h", out_valid, out_client, out_data);
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h40 + 8'(i)) $display("FAIL full_pop%0d: got v=%b d=%h expected 1 %h", i, out_valid, out_data, 8'h40 + 8'(i)); else pass_cnt++;
    end
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL full_dropped: got v=%b d=%h expected v=0", out_valid, out_data); else pass_cnt++;
    grant = 2'b00;
  endtask

  task automatic test_stale();
    do_reset();
    grant = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stale_no_pop%0d: got v=%b expected 0", i, out_valid); else pass_cnt++;
    end
    grant = 2'b00;
`ifdef ARBQ_STALE_CNT_EN
    total_cnt++; if (stale_cnt !== 8'd3) $display("FAIL stale_cnt: got %0d expected 3", stale_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    grant = 2'b01;
    in_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      in_data0 = 8'h30 + 8'(i);
      step();
      total_cnt++; if (in_ready[0] !== 1'b1 || request[0] !== 1'b1) $display("FAIL wrap_flags%0d: got ready=%b req=%b expected 1 1", i, in_ready[0], request[0]); else pass_cnt++;
      if (i >= 1) begin
        $display("pop wrap: v=%b d=%h", out_valid, out_data);
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h30 + 8'(i - 1)) $display("FAIL wrap_pop%0d: got v=%b d=%h expected 1 %h", i - 1, out_valid, out_data, 8'h30 + 8'(i - 1)); else pass_cnt++;
      end
    end
    in_valid = 2'b00;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h39) $display("FAIL wrap_pop9: got v=%b d=%h expected 1 39", out_valid, out_data); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || request !== 2'b00) $display("FAIL wrap_end: got v=%b req=%b expected 0 00", out_valid, request); else pass_cnt++;
    grant = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_client();
    test_tie();
    test_full();
    test_stale();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
